// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int DEF_N_REQ      = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin selector: first asserted request scanning upward from the
// requester after last_i, wrapping modulo N_REQ. Purely combinational.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N_REQ-1:0] pick_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // Walk candidates in priority order; the first hit wins.
   always_comb begin
      pick_o = '0;
      idx_o  = '0;
      found  = 1'b0;
      cand   = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand = IDX_W'((int'(last_i) + off) % N_REQ);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            pick_o[cand] = 1'b1;
            idx_o        = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// One owner at a time, bounded bursts, stalls on full, per-beat acks.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                        full,
   output logic [N_REQ-1:0]            grant,
   output logic [N_REQ-1:0]            req_ack,
   output logic                        w_enable,
   output logic [DATA_WIDTH-1:0]       write_data,
   output logic                        busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   arb_state_t            state_q;
   logic [N_REQ-1:0]      grant_q;
   logic [CNT_W-1:0]      beat_cnt_q;
   logic [CNT_W-1:0]      beat_cnt_d;
   logic [IDX_W-1:0]      last_q;

   logic [N_REQ-1:0]      pick;
   logic [IDX_W-1:0]      pick_idx;
   logic                  owner_req;
   logic                  beat;
   logic [DATA_WIDTH-1:0] wdata_mux;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i  (req),
      .last_i (last_q),
      .pick_o (pick),
      .idx_o  (pick_idx)
   );

   assign grant = grant_q;
   assign busy  = (state_q == GRANT);

   // Write-side outputs decoded from the registered grant; grant_q is zero
   // in IDLE, so the mux and the owner's request both collapse to zero there.
   always_comb begin
      owner_req = |(req & grant_q);
      wdata_mux = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[IDX_W'(i)]) begin
            wdata_mux = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      beat       = busy && owner_req && !full && !reset;
      beat_cnt_d = beat_cnt_q + 1'b1;
      w_enable   = beat;
      req_ack    = beat ? grant_q : '0;
      write_data = busy ? wdata_mux : '0;
   end

   // Arbitration FSM: pick in IDLE, hold the owner through its burst, release
   // on request drop or on the capping beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         last_q     <= IDX_LAST;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q    <= GRANT;
                  grant_q    <= pick;
                  last_q     <= pick_idx;
                  beat_cnt_q <= '0;
               end
            end
            GRANT: begin
               if (!owner_req) begin
                  state_q    <= IDLE;
                  grant_q    <= '0;
                  beat_cnt_q <= '0;
               end else if (beat) begin
                  if (beat_cnt_q == CNT_LAST) begin
                     state_q    <= IDLE;
                     grant_q    <= '0;
                     beat_cnt_q <= '0;
                  end else begin
                     beat_cnt_q <= beat_cnt_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a MAX_BURST=4 instance for the main
// scenarios and a MAX_BURST=2 instance for the burst-cap scenario.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    req_a, req_b;
   logic [N*DW-1:0] rd_a, rd_b;
   logic            full_a, full_b;
   logic [N-1:0]    grant_a, grant_b, ack_a, ack_b;
   logic            wen_a, wen_b, busy_a, busy_b;
   logic [DW-1:0]   wd_a, wd_b;

   fifo_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut_a (
      .clock(clk), .reset(rst), .req(req_a), .req_data(rd_a), .full(full_a),
      .grant(grant_a), .req_ack(ack_a), .w_enable(wen_a), .write_data(wd_a), .busy(busy_a)
   );

   fifo_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(2)) dut_b (
      .clock(clk), .reset(rst), .req(req_b), .req_data(rd_b), .full(full_b),
      .grant(grant_b), .req_ack(ack_b), .w_enable(wen_b), .write_data(wd_b), .busy(busy_b)
   );

   typedef struct {
      int         r;
      logic [7:0] d;
   } sb_t;

   typedef struct {
      logic [3:0] req;
      logic       full;
      logic [7:0] d0;
      logic [3:0] g;
      logic       wen;
      logic [3:0] ack;
      logic [7:0] wd;
      logic       busy;
   } vec_t;

   sb_t  sb_a[$];
   sb_t  sb_b[$];
   vec_t tbl[10];

   int n_tests = 0;
   int n_fail  = 0;

   int rem_a[N], nxt_a[N], psh_a[N];
   int rem_b[N], nxt_b[N], psh_b[N];
   bit auto_p;

   logic [N-1:0]  s_grant_a, s_ack_a, s_grant_b, s_ack_b;
   logic          s_wen_a, s_busy_a, s_wen_b, s_busy_b;
   logic [DW-1:0] s_wd_a, s_wd_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] dat(input int r, input int n);
      return 8'((r + 1) * 16 + n);
   endfunction

   // Producers present their next word and hold req while words remain.
   task automatic drive_p();
      for (int i = 0; i < N; i++) begin
         req_a[i]            = (rem_a[i] > 0);
         rd_a[i*DW +: DW]    = dat(i, nxt_a[i]);
         req_b[i]            = (rem_b[i] > 0);
         rd_b[i*DW +: DW]    = dat(i, nxt_b[i]);
      end
   endtask

   task automatic push_a(input int r, input int k);
      for (int j = 0; j < k; j++) begin
         sb_a.push_back('{r, dat(r, psh_a[r])});
         psh_a[r]++;
      end
   endtask

   task automatic push_b(input int r, input int k);
      for (int j = 0; j < k; j++) begin
         sb_b.push_back('{r, dat(r, psh_b[r])});
         psh_b[r]++;
      end
   endtask

   // One clock: sample at the falling edge, score writes, then advance producers.
   task automatic cyc();
      sb_t e;
      @(negedge clk);
      s_grant_a = grant_a; s_ack_a = ack_a; s_wen_a = wen_a; s_wd_a = wd_a; s_busy_a = busy_a;
      s_grant_b = grant_b; s_ack_b = ack_b; s_wen_b = wen_b; s_wd_b = wd_b; s_busy_b = busy_b;
      if (full_a) chk("full_excl_a", {31'b0, wen_a}, 32'd0);
      if (s_wen_a) begin
         chk("sb_a_pending", 32'(sb_a.size() > 0), 32'd1);
         if (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            chk("wdata_a", {24'b0, s_wd_a}, {24'b0, e.d});
            chk("ack_a", {28'b0, s_ack_a}, 32'(1 << e.r));
         end
      end
      if (s_wen_b) begin
         chk("sb_b_pending", 32'(sb_b.size() > 0), 32'd1);
         if (sb_b.size() > 0) begin
            e = sb_b.pop_front();
            chk("wdata_b", {24'b0, s_wd_b}, {24'b0, e.d});
            chk("ack_b", {28'b0, s_ack_b}, 32'(1 << e.r));
         end
      end
      @(posedge clk);
      #1;
      if (auto_p) begin
         for (int i = 0; i < N; i++) begin
            if (s_ack_a[i]) begin rem_a[i]--; nxt_a[i]++; end
            if (s_ack_b[i]) begin rem_b[i]--; nxt_b[i]++; end
         end
         drive_p();
      end
   endtask

   bit bc_wen[10] = '{0, 1, 1, 0, 1, 1, 0, 1, 0, 0};
   bit bc_g[10]   = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};

   initial begin
      //              req    full d0     g      wen  ack    wd     busy
      tbl[0] = '{4'b0001, 1'b0, 8'hA1, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};
      tbl[1] = '{4'b0001, 1'b0, 8'hA1, 4'b0001, 1'b1, 4'b0001, 8'hA1, 1'b1};
      tbl[2] = '{4'b0001, 1'b0, 8'hA2, 4'b0001, 1'b1, 4'b0001, 8'hA2, 1'b1};
      tbl[3] = '{4'b0001, 1'b0, 8'hA3, 4'b0001, 1'b1, 4'b0001, 8'hA3, 1'b1};
      tbl[4] = '{4'b0000, 1'b0, 8'hA3, 4'b0001, 1'b0, 4'b0000, 8'hA3, 1'b1};
      tbl[5] = '{4'b0000, 1'b0, 8'hA3, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};
      tbl[6] = '{4'b0001, 1'b1, 8'hB1, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};
      tbl[7] = '{4'b0001, 1'b1, 8'hB1, 4'b0001, 1'b0, 4'b0000, 8'hB1, 1'b1};
      tbl[8] = '{4'b0000, 1'b0, 8'hB1, 4'b0001, 1'b0, 4'b0000, 8'hB1, 1'b1};
      tbl[9] = '{4'b0000, 1'b0, 8'hB1, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};

      rst = 1'b1; full_a = 1'b0; full_b = 1'b0; auto_p = 1'b1;
      drive_p();
      cyc(); cyc();
      chk("rst_grant_a", {28'b0, s_grant_a}, 32'd0);
      chk("rst_busy_a",  {31'b0, s_busy_a},  32'd0);
      chk("rst_wen_a",   {31'b0, s_wen_a},   32'd0);
      chk("rst_wdata_a", {24'b0, s_wd_a},    32'd0);
      chk("rst_grant_b", {28'b0, s_grant_b}, 32'd0);
      rst = 1'b0;

      // Single requester and a stalled grant, driven from the vector table.
      auto_p = 1'b0;
      for (int i = 0; i < 10; i++) begin
         req_a  = tbl[i].req;
         full_a = tbl[i].full;
         rd_a   = {24'h0, tbl[i].d0};
         if (tbl[i].wen) sb_a.push_back('{0, tbl[i].d0});
         cyc();
         chk("tbl_grant", {28'b0, s_grant_a}, {28'b0, tbl[i].g});
         chk("tbl_wen",   {31'b0, s_wen_a},   {31'b0, tbl[i].wen});
         chk("tbl_ack",   {28'b0, s_ack_a},   {28'b0, tbl[i].ack});
         chk("tbl_wdata", {24'b0, s_wd_a},    {24'b0, tbl[i].wd});
         chk("tbl_busy",  {31'b0, s_busy_a},  {31'b0, tbl[i].busy});
      end
      full_a = 1'b0;
      auto_p = 1'b1;
      drive_p();
      chk("tbl_sb_empty", 32'(sb_a.size()), 32'd0);

      // Contention: all four requesters high after reset.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < N; i++) rem_a[i] = 8;
      for (int g = 0; g < 5; g++) push_a(g % 4, 4);
      drive_p();
      for (int c = 0; c < 25; c++) begin
         cyc();
         chk("cont_wen", {31'b0, s_wen_a}, 32'((c % 5) != 0));
         if (c % 5 == 1) chk("cont_grant", {28'b0, s_grant_a}, 32'(1 << ((c / 5) % 4)));
         if (c % 5 == 0) chk("cont_bubble", {28'b0, s_grant_a}, 32'd0);
      end
      for (int i = 0; i < N; i++) rem_a[i] = 0;
      drive_p();
      cyc();
      chk("cont_sb_empty", 32'(sb_a.size()), 32'd0);

      // Full stall after the first beat of owner 1.
      rem_a[1] = 6;
      push_a(1, 4);
      drive_p();
      for (int c = 0; c < 9; c++) begin
         full_a = (c >= 2 && c <= 4);
         if (c == 8) begin rem_a[1] = 0; drive_p(); end
         cyc();
         chk("stall_wen", {31'b0, s_wen_a}, 32'(c == 1 || (c >= 5 && c <= 7)));
         if (c >= 1 && c <= 7) chk("stall_grant", {28'b0, s_grant_a}, 32'b0010);
         if (c >= 2 && c <= 4) chk("stall_ack", {28'b0, s_ack_a}, 32'd0);
         if (c == 8) chk("stall_release", {31'b0, s_busy_a}, 32'd0);
      end
      full_a = 1'b0;
      chk("stall_sb_empty", 32'(sb_a.size()), 32'd0);

      // Reset during owner 3's second beat, then requesters 1 and 3 compete.
      rem_a[3] = 4;
      push_a(3, 1);
      drive_p();
      for (int c = 0; c < 13; c++) begin
         rst = (c == 2);
         if (c == 3) begin
            rem_a[1] = 2;
            drive_p();
            push_a(1, 2);
            push_a(3, 3);
         end
         cyc();
         if (c == 1) chk("rstm_grant3", {28'b0, s_grant_a}, 32'b1000);
         if (c == 2) chk("rstm_wen_low", {31'b0, s_wen_a}, 32'd0);
         if (c == 3) begin
            chk("rstm_grant0", {28'b0, s_grant_a}, 32'd0);
            chk("rstm_busy0",  {31'b0, s_busy_a},  32'd0);
            chk("rstm_wen0",   {31'b0, s_wen_a},   32'd0);
         end
         if (c == 4) chk("rstm_win1", {28'b0, s_grant_a}, 32'b0010);
         if (c == 8) chk("rstm_then3", {28'b0, s_grant_a}, 32'b1000);
      end
      rst = 1'b0;
      chk("rstm_sb_empty", 32'(sb_a.size()), 32'd0);

      // Early release of owner 0 while requester 1 waits.
      rem_a[0] = 1;
      rem_a[1] = 2;
      push_a(0, 1);
      push_a(1, 2);
      drive_p();
      for (int c = 0; c < 7; c++) begin
         cyc();
         if (c == 1) chk("early_beat0", {31'b0, s_wen_a}, 32'd1);
         if (c == 2) begin
            chk("early_grant_hold", {28'b0, s_grant_a}, 32'b0001);
            chk("early_no_wen",     {31'b0, s_wen_a},   32'd0);
            chk("early_no_ack",     {28'b0, s_ack_a},   32'd0);
         end
         if (c == 3) chk("early_idle", {31'b0, s_busy_a}, 32'd0);
         if (c == 4) chk("early_grant1", {28'b0, s_grant_a}, 32'b0010);
      end
      chk("early_sb_empty", 32'(sb_a.size()), 32'd0);

      // Burst cap of 2 with requester 2 alone for five words.
      rem_b[2] = 5;
      push_b(2, 5);
      drive_p();
      for (int c = 0; c < 10; c++) begin
         cyc();
         chk("cap_wen", {31'b0, s_wen_b}, {31'b0, bc_wen[c]});
         chk("cap_grant", {28'b0, s_grant_b}, bc_g[c] ? 32'b0100 : 32'd0);
      end
      chk("cap_sb_empty", 32'(sb_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that lets N_REQ producers share the single write port of the 16x8 synchronous FIFO. It grants one requester at a time for a bounded burst and forwards that requester's data and enable to the FIFO. It stalls on FIFO `full` and returns per-beat acknowledges to the producers. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, data width; equals the FIFO width
- MAX_BURST, 4, maximum beats written per grant (1..16)
- clock  in  1  rising-edge clock shared with the FIFO
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester write request; a requester holds it high while it has data
- req_data  in  N_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- full  in  1  FIFO full flag
- grant  out  N_REQ  one-hot owner of the write port; all zeros when idle
- req_ack  out  N_REQ  one-hot; the beat from requester i is written this cycle; the producer advances its data on the next edge
- w_enable  out  1  FIFO write enable
- write_data  out  DATA_WIDTH  FIFO write data
- busy  out  1  high while in GRANT

## Operation
- One clock; reset is synchronous and active-high (`clock`, `reset`).
- States: IDLE, GRANT. Reset → IDLE, grant=0, beat_cnt=0, last_winner=N_REQ-1, so requester 0 has top priority after reset.
- IDLE:
  - If req != 0, pick the first asserted req scanning upward (modulo N_REQ) from last_winner+1.
  - Register the pick into grant (one-hot), set last_winner to the pick, clear beat_cnt, go to GRANT.
  - If req == 0, stay in IDLE.
- GRANT with owner g:
  - beat = req[g] && !full.
  - w_enable = beat; req_ack[g] = beat; write_data = req_data[g] (data is driven even when w_enable=0).
  - Each beat increments beat_cnt.
- Release GRANT → IDLE, grant ← 0, on either condition:
  - req[g] low at a clock edge; no beat occurs that cycle;
  - a beat occurs while beat_cnt == MAX_BURST-1 (the burst cap; the capping beat is written).
- full stalls in place: no beat, beat_cnt holds, and the grant is kept while req[g] stays high. There is no timeout.
- Outputs are never X:
  - w_enable, req_ack = 0 outside GRANT.
  - write_data = 0 in IDLE.
- Requests from non-owners are ignored until the next IDLE arbitration. A non-owner's req may rise or fall freely.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - last_winner is $clog2(N_REQ) bits and wraps from N_REQ-1 to 0.

## Timing
- Arbitration latency: req rising in IDLE at edge k gives grant at edge k+1. The first write can occur in cycle k+1, i.e. captured by the FIFO at edge k+2.
- Each release costs one IDLE bubble cycle, so peak throughput is MAX_BURST/(MAX_BURST+1) with contending requesters.
- w_enable, req_ack and write_data are combinational from the registered grant, req, full and req_data. There is no combinational path from req to grant.
- full and w_enable in the same cycle can never both be high.
- Reset asserted mid-burst: at the next edge the block is in IDLE with grant=0 and last_winner=N_REQ-1. w_enable is forced low during any cycle reset is high.
- Simultaneous release and a new request from another requester: the release completes first, then arbitration happens in the IDLE cycle.

## Structure
- Package fifo_arb_pkg:
  - arb_state_t enum {IDLE, GRANT};
  - default localparams for N_REQ, DATA_WIDTH, MAX_BURST.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req and last_winner.
  - Outputs: a one-hot pick and its index.
  - Instantiated once in the IDLE path.
- Top module: state register, beat counter, grant register and output mux.

## Test plan
- Single requester, MAX_BURST=4: req[0] high for 3 beats with data 0xA1,0xA2,0xA3, then low.
  - Required: grant=0001 one cycle after req.
  - Required: 3 w_enable pulses with write_data A1,A2,A3; req_ack[0] on the same cycles; back to IDLE after req drops.
- Contention, all 4 requesters continuously high after reset.
  - Required grant order: 0,1,2,3,0.
  - Required: each grant writes exactly 4 beats, with one idle bubble between grants.
- Burst cap, MAX_BURST=2: req[2] high for 5 beats.
  - Required: two grants of 2 beats, then a third grant of 1 beat. Requester 2 is re-granted when it is the only requester.
- full stall: full high for 3 cycles in mid-burst after beat 1 of owner 1.
  - Required: w_enable=0 and req_ack=0 during the stall.
  - Required: grant held, beat_cnt held, burst resumes with beat 2 after full drops, total beats still 4.
- Reset mid-burst: reset pulsed during owner 3's second beat.
  - Required: next cycle grant=0, busy=0, w_enable=0.
  - Required: with reqs 1 and 3 then high, requester 1 wins, since priority restarts at 0.
- Early release: owner 0 drops req after 1 beat while req[1] is high.
  - Required: one IDLE cycle, then grant=0010.
  - Required: no beat from requester 0 in the cycle its req was low.
